// File: rtl/stopwatch_scan_driver.sv
// -----------------------------------------------------------------------------
// stopwatch_scan_driver
//
// Time-multiplexed scan driver for the stopwatch's 5-digit display.
//
// A prescaler divides clk down to one digit slot every DIV cycles. On each slot
// boundary the digit index advances 0 -> 1 -> 2 -> 3 -> 4 -> 0. The matching
// BCD digit and decimal point are presented for that index.
//
// Anti-ghosting: digit_on is forced low for BLANK_CYCLES cycles at the start of
// every slot. This gives the segment lines time to settle before the new
// position is lit.
//
// Anti-tearing: the digit data is captured into a frame register only when the
// index wraps 4 -> 0, and once right after reset. A whole frame is therefore
// drawn from one consistent snapshot.
//
// Leading-zero suppression (LZB=1): a digit i >= 1 stays dark for its whole
// slot when it, and every digit above it in the frame, is zero.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; 0 freezes scanning and blanks the display
//   digits_in   five packed BCD digits, [3:0] = digit 0 ... [19:16] = digit 4
//   dp_in       decimal point per digit, bit i belongs to digit i
//   scan_index  current digit index 0..4, drives the 3-to-5 position decoder
//   bcd_out     BCD value of the current digit
//   dp_out      decimal point of the current digit
//   digit_on    1 when the current digit may be lit
// -----------------------------------------------------------------------------
module stopwatch_scan_driver #(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter bit          LZB          = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [19:0] digits_in,
    input  logic [4:0]  dp_in,
    output logic [2:0]  scan_index,
    output logic [3:0]  bcd_out,
    output logic        dp_out,
    output logic        digit_on
);

    // Counter widths: the prescaler must hold DIV-1.
    // The blank counter must hold BLANK_CYCLES.
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_LOAD   = BLK_W'(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLK_ONE    = BLK_W'(1);
    localparam logic [2:0]       LAST_INDEX = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;            // prescaler, 0..DIV-1
    logic [BLK_W-1:0] blank_cnt;      // remaining blank cycles in this slot
    logic [19:0]      frame_digits;   // per-frame snapshot of digits_in
    logic [4:0]       frame_dp;       // per-frame snapshot of dp_in
    logic             load_pending;   // first cycle after reset: take a snapshot

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    logic             tick;
    logic [2:0]       index_next;
    logic             frame_load;
    logic [19:0]      src_digits;
    logic [4:0]       src_dp;
    logic [BLK_W-1:0] blank_next;
    logic [3:0]       sel_bcd;
    logic             sel_dp;
    logic             sel_upper_zero;
    logic             lit_next;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // a combinational output unassigned and no latch is inferred.
        tick       = en && (cnt == CNT_MAX);
        index_next = scan_index;
        if (tick) begin
            index_next = (scan_index == LAST_INDEX) ? 3'd0 : scan_index + 3'd1;
        end

        // The snapshot is taken on the 4 -> 0 wrap and on the post-reset load.
        // In that same cycle the outputs are fed from the live inputs.
        // This lets the digit shown at T+1 come from the freshly loaded data.
        frame_load = load_pending || (tick && (index_next == 3'd0));
        src_digits = frame_load ? digits_in : frame_digits;
        src_dp     = frame_load ? dp_in     : frame_dp;

        // A tick reloads the blank counter.
        // Otherwise the counter runs down to zero and sticks there.
        blank_next = blank_cnt;
        if (tick) begin
            blank_next = BLK_LOAD;
        end else if (blank_cnt != '0) begin
            blank_next = blank_cnt - BLK_ONE;
        end
    end

    // Digit/dp selection for the index shown next cycle.
    // sel_upper_zero reports whether this digit and all digits above it are 0.
    // Digit 0 never reports that, so it is never suppressed.
    always_comb begin
        sel_bcd        = 4'd0;
        sel_dp         = 1'b0;
        sel_upper_zero = 1'b0;
        case (index_next)
            3'd0: begin
                sel_bcd        = src_digits[3:0];
                sel_dp         = src_dp[0];
                sel_upper_zero = 1'b0;
            end
            3'd1: begin
                sel_bcd        = src_digits[7:4];
                sel_dp         = src_dp[1];
                sel_upper_zero = (src_digits[19:4] == 16'd0);
            end
            3'd2: begin
                sel_bcd        = src_digits[11:8];
                sel_dp         = src_dp[2];
                sel_upper_zero = (src_digits[19:8] == 12'd0);
            end
            3'd3: begin
                sel_bcd        = src_digits[15:12];
                sel_dp         = src_dp[3];
                sel_upper_zero = (src_digits[19:12] == 8'd0);
            end
            3'd4: begin
                sel_bcd        = src_digits[19:16];
                sel_dp         = src_dp[4];
                sel_upper_zero = (src_digits[19:16] == 4'd0);
            end
            default: begin
                sel_bcd        = 4'd0;
                sel_dp         = 1'b0;
                sel_upper_zero = 1'b0;
            end
        endcase

        // Lit once the blank window has run out, unless this is a leading zero.
        // Out of reset the blank counter is already 0, so slot 0 lights at once.
        lit_next = (blank_next == '0) && !(LZB && sel_upper_zero);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only.
    // Every register then samples the pre-edge values of the decode above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            blank_cnt    <= '0;
            // NOTE: the frame register is reset as well, even though it is
            // overwritten on the first cycle. The selection and suppression
            // logic read it, so it must never carry X into the outputs.
            frame_digits <= 20'd0;
            frame_dp     <= 5'd0;
            load_pending <= 1'b1;
            scan_index   <= 3'd0;
            bcd_out      <= 4'd0;
            dp_out       <= 1'b0;
            digit_on     <= 1'b0;
        end else begin
            // The snapshot does not depend on en.
            // The post-reset load happens even while scanning is frozen.
            if (frame_load) begin
                frame_digits <= digits_in;
                frame_dp     <= dp_in;
            end
            load_pending <= 1'b0;

            if (en) begin
                cnt        <= tick ? '0 : cnt + CNT_ONE;
                blank_cnt  <= blank_next;
                scan_index <= index_next;
                bcd_out    <= sel_bcd;
                dp_out     <= sel_dp;
                digit_on   <= lit_next;
            end else begin
                // Frozen: counters, index and digit data hold; the display goes dark.
                digit_on <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_scan_driver
//
// Self-checking bench for stopwatch_scan_driver. Three instances share the
// clock, reset and enable:
//   u_a: DIV=4, BLANK_CYCLES=1, LZB=0   basic scan, mid-frame update, en, reset
//   u_b: DIV=4, BLANK_CYCLES=1, LZB=1   leading-zero suppression
//   u_c: DIV=2, BLANK_CYCLES=0, LZB=0   fast scan, no blanking, one-hot index
//
// Expected values come from closed-form slot arithmetic. Edge k is the k-th
// rising edge after reset release. For DIV=4, the index after edge k is
// ((k+1)/4)%5, and the first cycle of every slot is dark.
// -----------------------------------------------------------------------------
module tb_stopwatch_scan_driver;

    localparam int NVEC = 100;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [19:0] digits_a;
    logic [4:0]  dp_a;
    logic [19:0] digits_b;
    logic [4:0]  dp_b;

    logic [2:0]  scan_index_a, scan_index_b, scan_index_c;
    logic [3:0]  bcd_out_a,    bcd_out_b,    bcd_out_c;
    logic        dp_out_a,     dp_out_b,     dp_out_c;
    logic        digit_on_a,   digit_on_b,   digit_on_c;

    int checks = 0;
    int errors = 0;

    stopwatch_scan_driver #(.DIV(4), .BLANK_CYCLES(1), .LZB(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_a), .dp_in(dp_a),
        .scan_index(scan_index_a), .bcd_out(bcd_out_a), .dp_out(dp_out_a),
        .digit_on(digit_on_a)
    );

    stopwatch_scan_driver #(.DIV(4), .BLANK_CYCLES(1), .LZB(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_b), .dp_in(dp_b),
        .scan_index(scan_index_b), .bcd_out(bcd_out_b), .dp_out(dp_out_b),
        .digit_on(digit_on_b)
    );

    stopwatch_scan_driver #(.DIV(2), .BLANK_CYCLES(0), .LZB(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_a), .dp_in(dp_a),
        .scan_index(scan_index_c), .bcd_out(bcd_out_c), .dp_out(dp_out_c),
        .digit_on(digit_on_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector = inputs driven before edge k + outputs expected after it.
    typedef struct {
        logic [19:0] din_a;
        logic [4:0]  dpin_a;
        logic [19:0] din_b;
        logic [2:0]  idx_a;
        logic [3:0]  bcd_a;
        logic        dp_a;
        logic        on_a;
        logic [2:0]  idx_b;
        logic [3:0]  bcd_b;
        logic        dp_b;
        logic        on_b;
        logic [2:0]  idx_c;
        logic [3:0]  bcd_c;
        logic        on_c;
    } vec_t;

    // Expected outputs of u_a alone, used by the hand-written sequences.
    typedef struct {
        logic [2:0] idx;
        logic [3:0] bcd;
        logic       dp;
        logic       on;
    } a_exp_t;

    vec_t   vecs [NVEC];
    vec_t   sb_q [$];
    a_exp_t a_q  [$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] nib(input logic [19:0] d, input int i);
        return d[i*4 +: 4];
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push expectation, clock, pop and compare u_a.
    task automatic run_a(input string tag, input logic [2:0] idx, input logic [3:0] bcd,
                         input logic dp, input logic on);
        a_exp_t e;
        a_exp_t got;
        e.idx = idx; e.bcd = bcd; e.dp = dp; e.on = on;
        a_q.push_back(e);
        step();
        got = a_q.pop_front();
        check({tag, " idx"}, 32'(scan_index_a), 32'(got.idx));
        check({tag, " bcd"}, 32'(bcd_out_a),    32'(got.bcd));
        check({tag, " dp"},  32'(dp_out_a),     32'(got.dp));
        check({tag, " on"},  32'(digit_on_a),   32'(got.on));
    endtask

    initial begin
        vec_t        v;
        logic [4:0]  onehot;
        logic [19:0] frame;
        logic [4:0]  fdp;
        int          ia;

        dp_b = 5'b01010;

        // ---- Build the vector table from slot arithmetic -------------------
        for (int k = 0; k < NVEC; k++) begin
            // Inputs change while index 2 is showing (before edge 10).
            vecs[k].din_a  = (k < 10) ? 20'h12345 : 20'h98765;
            vecs[k].dpin_a = (k < 10) ? 5'b10100 : 5'b11010;
            vecs[k].din_b  = (k < 10) ? 20'h00012 : 20'h00000;

            ia = ((k + 1) / 4) % 5;
            // First frame was captured at edge 0; the next at the wrap on edge 19.
            frame = ((k + 1) < 20) ? 20'h12345 : 20'h98765;
            fdp   = ((k + 1) < 20) ? 5'b10100 : 5'b11010;
            vecs[k].idx_a = 3'(ia);
            vecs[k].bcd_a = nib(frame, ia);
            vecs[k].dp_a  = fdp[ia];
            vecs[k].on_a  = ((k + 1) % 4) != 0;

            frame = ((k + 1) < 20) ? 20'h00012 : 20'h00000;
            vecs[k].idx_b = 3'(ia);
            vecs[k].bcd_b = nib(frame, ia);
            vecs[k].dp_b  = dp_b[ia];
            vecs[k].on_b  = (((k + 1) % 4) != 0) && ((ia == 0) || ((frame >> (4 * ia)) != 20'd0));

            // u_c wraps at edges 9, 19, ...; the edge-19 wrap picks up the new digits.
            ia = ((k + 1) / 2) % 5;
            frame = ((k + 1) < 20) ? 20'h12345 : 20'h98765;
            vecs[k].idx_c = 3'(ia);
            vecs[k].bcd_c = nib(frame, ia);
            vecs[k].on_c  = 1'b1;
        end

        // ---- Reset state ----------------------------------------------------
        rst_n    = 1'b0;
        en       = 1'b1;
        digits_a = 20'h12345;
        dp_a     = 5'b10100;
        digits_b = 20'h00012;
        step();
        step();
        check("reset idx_a", 32'(scan_index_a), 32'd0);
        check("reset bcd_a", 32'(bcd_out_a),    32'd0);
        check("reset dp_a",  32'(dp_out_a),     32'd0);
        check("reset on_a",  32'(digit_on_a),   32'd0);
        check("reset on_b",  32'(digit_on_b),   32'd0);
        check("reset idx_c", 32'(scan_index_c), 32'd0);
        check("reset on_c",  32'(digit_on_c),   32'd0);
        rst_n = 1'b1;

        // ---- Table-driven run -------------------------------------------------
        for (int k = 0; k < NVEC; k++) begin
            digits_a = vecs[k].din_a;
            dp_a     = vecs[k].dpin_a;
            digits_b = vecs[k].din_b;
            sb_q.push_back(vecs[k]);
            step();
            v = sb_q.pop_front();
            check($sformatf("k%0d idx_a", k), 32'(scan_index_a), 32'(v.idx_a));
            check($sformatf("k%0d bcd_a", k), 32'(bcd_out_a),    32'(v.bcd_a));
            check($sformatf("k%0d dp_a", k),  32'(dp_out_a),     32'(v.dp_a));
            check($sformatf("k%0d on_a", k),  32'(digit_on_a),   32'(v.on_a));
            check($sformatf("k%0d idx_b", k), 32'(scan_index_b), 32'(v.idx_b));
            check($sformatf("k%0d bcd_b", k), 32'(bcd_out_b),    32'(v.bcd_b));
            check($sformatf("k%0d dp_b", k),  32'(dp_out_b),     32'(v.dp_b));
            check($sformatf("k%0d on_b", k),  32'(digit_on_b),   32'(v.on_b));
            check($sformatf("k%0d idx_c", k), 32'(scan_index_c), 32'(v.idx_c));
            check($sformatf("k%0d bcd_c", k), 32'(bcd_out_c),    32'(v.bcd_c));
            check($sformatf("k%0d on_c", k),  32'(digit_on_c),   32'(v.on_c));
            onehot = 5'b00001 << scan_index_c;
            check($sformatf("k%0d onehot_c", k), 32'($countones(onehot)), 32'd1);
        end

        // ---- en pause mid-slot at index 3 ------------------------------------
        rst_n    = 1'b0;
        digits_a = 20'h12345;
        dp_a     = 5'b10100;
        step();
        rst_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            ia = ((k + 1) / 4) % 5;
            run_a($sformatf("en_pre k%0d", k), 3'(ia), nib(20'h12345, ia),
                  dp_a[ia], ((k + 1) % 4) != 0);
        end
        // After edge 12: index 3 with prescaler at 1.
        en = 1'b0;
        for (int k = 13; k <= 22; k++) begin
            run_a($sformatf("en_off k%0d", k), 3'd3, 4'h2, 1'b0, 1'b0);
        end
        en = 1'b1;
        run_a("en_on k23", 3'd3, 4'h2, 1'b0, 1'b1);
        run_a("en_on k24", 3'd3, 4'h2, 1'b0, 1'b1);
        run_a("en_on k25", 3'd4, 4'h1, 1'b1, 1'b0);
        run_a("en_on k26", 3'd4, 4'h1, 1'b1, 1'b1);

        // ---- Asynchronous reset mid-slot at index 4 --------------------------
        rst_n    = 1'b0;
        digits_a = 20'h40321;
        dp_a     = 5'b00011;
        #2;
        check("async idx_a", 32'(scan_index_a), 32'd0);
        check("async bcd_a", 32'(bcd_out_a),    32'd0);
        check("async dp_a",  32'(dp_out_a),     32'd0);
        check("async on_a",  32'(digit_on_a),   32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            ia = ((k + 1) / 4) % 5;
            run_a($sformatf("post_rst k%0d", k), 3'(ia), nib(20'h40321, ia),
                  dp_a[ia], ((k + 1) % 4) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
